// File: rtl/e_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package e_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Index width for an N-entry vector; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/e_rr_arb_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
interface e_rr_arb_if
  import e_pkg::*;
#(
  parameter int RADIX_N = 4
);
  logic [RADIX_N-1:0]       req;
  logic                     ack;
  logic                     gnt_vld;
  logic [RADIX_N-1:0]       gnt;
  logic [idx_w(RADIX_N)-1:0] gnt_idx;
  logic                     to;

  modport master (
    output req, ack,
    input  gnt_vld, gnt, gnt_idx, to
  );

  modport slave (
    input  req, ack,
    output gnt_vld, gnt, gnt_idx, to
  );
endinterface

// File: rtl/e_rr_pick.sv
// Combinational circular priority pick: first set request at or after ptr_i.
module e_rr_pick
  import e_pkg::*;
#(
  parameter int RADIX_N = 4,
  parameter int IDX_W   = idx_w(RADIX_N)
) (
  input  logic [RADIX_N-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [RADIX_N-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    sum      = '0;
    pos      = '0;
    for (int k = 0; k < RADIX_N; k++) begin
      // One extra bit so ptr + k cannot overflow before the modulo fold.
      sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(RADIX_N)) begin
        sum = sum - (IDX_W+1)'(RADIX_N);
      end
      pos = sum[IDX_W-1:0];
      if (!any_o && req_i[pos]) begin
        any_o         = 1'b1;
        idx_o         = pos;
        onehot_o[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/e_rr_arb.sv
// Round-robin arbiter with registered grant; optional watchdog enabled by
// defining E_RR_ARB_TIMEOUT_EN.
module e_rr_arb
  import e_pkg::*;
#(
  parameter int RADIX_N   = 4,
  parameter int TIMEOUT_N = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RADIX_N-1:0]         req_i,
  input  logic                       ack_i,
  output logic                       gnt_vld_o,
  output logic [RADIX_N-1:0]         gnt_o,
  output logic [$clog2(RADIX_N)-1:0] gnt_idx_o,
  output logic                       to_o
);

  localparam int IDX_W = idx_w(RADIX_N);

  if (RADIX_N < 2 || RADIX_N > 16 || TIMEOUT_N < 2) begin : g_bad_cfg
    $error("e_rr_arb: RADIX_N must be 2..16 and TIMEOUT_N at least 2");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, idx_q, idx_d;
  logic [RADIX_N-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   nxt_ptr, pick_ptr, pick_idx;
  logic [RADIX_N-1:0] pick_req, pick_oh;
  logic               pick_any;
  logic               timeout_w;

`ifdef E_RR_ARB_TIMEOUT_EN
  localparam int CNT_W = idx_w(TIMEOUT_N);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  assign timeout_w = (state_q == BUSY) && !ack_i && (cnt_q == CNT_W'(TIMEOUT_N - 1));
  assign to_o      = to_q;
`else
  assign timeout_w = 1'b0;
  assign to_o      = 1'b0;
`endif

  assign nxt_ptr  = (idx_q == IDX_W'(RADIX_N - 1)) ? '0 : idx_q + IDX_W'(1);
  // While busy, search from the post-release pointer and skip the current holder.
  assign pick_ptr = (state_q == BUSY) ? nxt_ptr : ptr_q;
  assign pick_req = req_i & ~gnt_q;

  e_rr_pick #(
    .RADIX_N (RADIX_N),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i    (pick_req),
    .ptr_i    (pick_ptr),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
`ifdef E_RR_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      BUSY: begin
`ifdef E_RR_ARB_TIMEOUT_EN
        to_d  = timeout_w;
        cnt_d = (ack_i || timeout_w) ? '0 : cnt_q + CNT_W'(1);
`endif
        if (ack_i || timeout_w) begin
          ptr_d = nxt_ptr;
          if (pick_any) begin
            gnt_d = pick_oh;
            idx_d = pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
          end
        end
      end
      default: begin
        if (pick_any) begin
          state_d = BUSY;
          gnt_d   = pick_oh;
          idx_d   = pick_idx;
`ifdef E_RR_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
`ifdef E_RR_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
`ifdef E_RR_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign gnt_vld_o = (state_q == BUSY);
  assign gnt_o     = gnt_q;
  assign gnt_idx_o = idx_q;

endmodule

// File: tb/tb_e_rr_arb.sv
// Scoreboard bench for e_rr_arb: directed vectors, expected grants queued by
// the stimulus and checked by a negedge monitor on every ack or timeout event.
module tb_e_rr_arb;

  localparam int N = 4;

  typedef struct {
    logic       is_to;
    logic [3:0] gnt;
    logic [1:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  e_rr_arb_if #(.RADIX_N(N)) bus ();

  e_rr_arb #(
    .RADIX_N   (N),
    .TIMEOUT_N (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (bus.req),
    .ack_i     (bus.ack),
    .gnt_vld_o (bus.gnt_vld),
    .gnt_o     (bus.gnt),
    .gnt_idx_o (bus.gnt_idx),
    .to_o      (bus.to)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic is_to, input logic [3:0] gnt, input logic [1:0] idx);
    exp_t e;
    e.is_to = is_to;
    e.gnt   = gnt;
    e.idx   = idx;
    sb.push_back(e);
  endtask

  // Monitor: an accepted grant or a timeout pulse is one transaction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ((bus.gnt_vld && bus.ack) || bus.to)) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got to=%b gnt=%b idx=%0d required none",
                 bus.to, bus.gnt, bus.gnt_idx);
      end else begin
        e = sb.pop_front();
        if (bus.to !== e.is_to || bus.gnt !== e.gnt || bus.gnt_idx !== e.idx) begin
          n_bad++;
          $display("FAIL sb_event: got to=%b gnt=%b idx=%0d required to=%b gnt=%b idx=%0d",
                   bus.to, bus.gnt, bus.gnt_idx, e.is_to, e.gnt, e.idx);
        end else begin
          $display("txn t=%0t to=%b gnt=%b idx=%0d ok", $time, bus.to, bus.gnt, bus.gnt_idx);
        end
      end
    end
  end

  initial begin
    bus.req = '0;
    bus.ack = 1'b0;

    // Reset state.
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_vld", 32'(bus.gnt_vld), 32'd0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_idx", 32'(bus.gnt_idx), 32'd0);
    chk("rst_to", 32'(bus.to), 32'd0);
    rst = 1'b0;

    // Single requester, one-cycle latency, ack returns to idle with ptr=1.
    bus.req = 4'b0001;
    push(1'b0, 4'b0001, 2'd0);
    #2 chk("no_early_vld", 32'(bus.gnt_vld), 32'd0);
    cyc();
    chk("lat_vld", 32'(bus.gnt_vld), 32'd1);
    chk("lat_gnt", 32'(bus.gnt), 32'b0001);
    bus.ack = 1'b1;
    cyc();
    bus.ack = 1'b0;
    bus.req = '0;
    chk("idle_after_ack", 32'(bus.gnt_vld), 32'd0);
    chk("idle_gnt_clear", 32'(bus.gnt), 32'd0);
    // ptr=1 is visible as the first pick of a full request.
    bus.req = 4'b1111;
    cyc();
    chk("ptr_after_ack", 32'(bus.gnt_idx), 32'd1);
    bus.req = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // All requesting, ack every cycle: 0,1,2,3,0 then 1 with no bubble.
    bus.req = 4'b1111;
    push(1'b0, 4'b0001, 2'd0);
    push(1'b0, 4'b0010, 2'd1);
    push(1'b0, 4'b0100, 2'd2);
    push(1'b0, 4'b1000, 2'd3);
    push(1'b0, 4'b0001, 2'd0);
    push(1'b0, 4'b0010, 2'd1);
    cyc();
    bus.ack = 1'b1;
    repeat (5) cyc();
    bus.req = '0;
    cyc();
    bus.ack = 1'b0;
    chk("b2b_idle", 32'(bus.gnt_vld), 32'd0);
    chk("b2b_drained", 32'(sb.size()), 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // Drive ptr to 3, then 0101 wraps to idx 0, then idx 2 back-to-back.
    bus.req = 4'b0100;
    push(1'b0, 4'b0100, 2'd2);
    cyc();
    bus.ack = 1'b1;
    cyc();
    bus.ack = 1'b0;
    bus.req = 4'b0101;
    push(1'b0, 4'b0001, 2'd0);
    cyc();
    chk("wrap_idx", 32'(bus.gnt_idx), 32'd0);
    bus.ack = 1'b1;
    cyc();
    bus.ack = 1'b0;
    bus.req = '0;
    chk("rearb_idx", 32'(bus.gnt_idx), 32'd2);
    chk("rearb_vld", 32'(bus.gnt_vld), 32'd1);

    // Requests vanish without ack: grant holds.
    repeat (3) cyc();
    chk("hold_gnt", 32'(bus.gnt), 32'b0100);
    chk("hold_vld", 32'(bus.gnt_vld), 32'd1);

    // Reset while busy with ack high: grant drops, ptr returns to 0.
    bus.ack = 1'b1;
    rst = 1'b1;
    cyc();
    chk("rst_busy_vld", 32'(bus.gnt_vld), 32'd0);
    chk("rst_busy_gnt", 32'(bus.gnt), 32'd0);
    rst = 1'b0;
    bus.ack = 1'b0;
    bus.req = 4'b1111;
    push(1'b0, 4'b0001, 2'd0);
    cyc();
    chk("rst_ptr_zero", 32'(bus.gnt_idx), 32'd0);
    bus.ack = 1'b1;
    bus.req = 4'b0001;
    cyc();
    bus.ack = 1'b0;
    bus.req = '0;

`ifdef E_RR_ARB_TIMEOUT_EN
    // Watchdog: idx 1 unacked for 8 busy cycles, pulse, then ptr=2.
    bus.req = 4'b0010;
    push(1'b1, 4'b0000, 2'd0);
    cyc();
    chk("to_gnt", 32'(bus.gnt), 32'b0010);
    repeat (7) cyc();
    chk("to_not_yet", 32'(bus.to), 32'd0);
    chk("to_still_vld", 32'(bus.gnt_vld), 32'd1);
    cyc();
    chk("to_pulse", 32'(bus.to), 32'd1);
    chk("to_dropped", 32'(bus.gnt_vld), 32'd0);
    bus.req = 4'b1111;
    push(1'b0, 4'b0100, 2'd2);
    cyc();
    chk("to_single", 32'(bus.to), 32'd0);
    chk("to_ptr2", 32'(bus.gnt_idx), 32'd2);
    bus.ack = 1'b1;
    bus.req = '0;
    cyc();
    bus.ack = 1'b0;
`endif

    cyc(); cyc();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "simulation time limit");
  end

endmodule
